calc_unit_arbiter: RTL



---
 rtl/calc_unit_arbiter_pkg.sv | 26 ++
 rtl/calc_unit_arbiter_if.sv | 28 ++
 rtl/calc_unit_arbiter_rr_arbiter.sv | 34 +++
 rtl/calc_unit_arbiter.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/calc_unit_arbiter_pkg.sv
// Shared definitions for the calculator-unit arbiter: operator codes,
// FSM state encoding and an operator legality helper.
package calc_pkg;

  localparam logic [2:0] OP_ADD = 3'b001;
  localparam logic [2:0] OP_SUB = 3'b010;
  localparam logic [2:0] OP_MUL = 3'b100;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_t;

  // Only the three one-hot operator codes map to a unit.
  function automatic logic op_is_legal(input logic [2:0] op);
    logic legal;
    case (op)
      OP_ADD, OP_SUB, OP_MUL: legal = 1'b1;
      default:                legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/calc_unit_arbiter_if.sv
// Request/response channel between the requesters and the arbiter.
// Per-requester fields are packed side by side, requester i in slice i.
interface calc_unit_arbiter_if #(
  parameter int NUM_REQ = 2,
  parameter int WIDTH   = 16
);
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_ready;
  logic [3*NUM_REQ-1:0]     req_op;
  logic [WIDTH*NUM_REQ-1:0] req_a;
  logic [WIDTH*NUM_REQ-1:0] req_b;
  logic [NUM_REQ-1:0]       rsp_valid;
  logic [NUM_REQ-1:0]       rsp_ready;
  logic [WIDTH-1:0]         rsp_data;
  logic                     rsp_error;

  // Requester side.
  modport master (
    output req_valid, req_op, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_error
  );

  // Arbiter side.
  modport slave (
    input  req_valid, req_op, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_error
  );
endinterface

// File: rtl/calc_unit_arbiter_rr_arbiter.sv
// Combinational round-robin picker: searches req starting just after
// last_grant and returns the first hit as one-hot grant plus its index.
module rr_arbiter #(
  parameter int NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] last_grant,
  output logic [NUM_REQ-1:0]         grant,
  output logic [$clog2(NUM_REQ)-1:0] grant_idx
);
  localparam int IDX_W = $clog2(NUM_REQ);

  logic [IDX_W-1:0] cand_s;
  logic             found_s;

  // Rotating priority search; the first valid requester after last_grant wins.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    cand_s    = '0;
    found_s   = 1'b0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      cand_s = IDX_W'((int'(last_grant) + off) % NUM_REQ);
      if (!found_s && req[cand_s]) begin
        grant[cand_s] = 1'b1;
        grant_idx     = cand_s;
        found_s       = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
  end

endmodule

// File: rtl/calc_unit_arbiter.sv
// Shares one adder/subtractor and one multiplier between NUM_REQ
// requesters. One operation in flight at a time; round-robin service;
// a unit that never finishes is abandoned after TIMEOUT_CYCLES.
module calc_unit_arbiter
  import calc_pkg::*;
#(
  parameter int NUM_REQ        = 2,
  parameter int WIDTH          = 16,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic               clk,
  input  logic               RST,
  calc_unit_arbiter_if.slave bus,
  output logic [WIDTH-1:0]   add_in1,
  output logic [WIDTH-1:0]   add_in2,
  output logic               add_sub,
  output logic               add_start,
  input  logic               add_finish,
  input  logic [WIDTH-1:0]   add_out,
  output logic [WIDTH-1:0]   mul_in1,
  output logic [WIDTH-1:0]   mul_in2,
  output logic               mul_start,
  input  logic               mul_finish,
  input  logic [WIDTH-1:0]   mul_out,
  output logic               busy
);
  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int TMR_W = $clog2(TIMEOUT_CYCLES) + 1;

  arb_state_t         state_q, state_d;
  logic [2:0]         op_q, op_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
  logic [IDX_W-1:0]   id_q, id_d;
  logic [IDX_W-1:0]   last_grant_q, last_grant_d;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic [WIDTH-1:0]   data_q, data_d;
  logic               err_q, err_d;
  logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
  logic               add_start_q, add_start_d;
  logic               mul_start_q, mul_start_d;
  logic               add_sub_q, add_sub_d;
  logic               busy_q, busy_d;

  logic [NUM_REQ-1:0] grant_s;
  logic [IDX_W-1:0]   grant_idx_s;
  logic               accept_s;
  logic [2:0]         sel_op_s;
  logic [WIDTH-1:0]   sel_a_s, sel_b_s;
  logic               fin_s;
  logic [WIDTH-1:0]   unit_res_s;
  logic [TMR_W-1:0]   timer_inc_s;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req        (bus.req_valid),
    .last_grant (last_grant_q),
    .grant      (grant_s),
    .grant_idx  (grant_idx_s)
  );

  // Grants are only offered while idle; the handshake happens on valid&ready.
  assign bus.req_ready = (state_q == IDLE) ? grant_s : '0;
  assign accept_s      = (state_q == IDLE) && (|grant_s);

  // Mux the granted requester's operator and operands out of the packed buses.
  always_comb begin
    sel_op_s = 3'b000;
    sel_a_s  = '0;
    sel_b_s  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_idx_s == IDX_W'(i)) begin
        sel_op_s = bus.req_op[i*3 +: 3];
        sel_a_s  = bus.req_a[i*WIDTH +: WIDTH];
        sel_b_s  = bus.req_b[i*WIDTH +: WIDTH];
      end else begin
        sel_op_s = sel_op_s;
      end
    end
  end

  // Only the dispatched unit's finish and result are of interest.
  always_comb begin
    if (op_q == OP_MUL) begin
      fin_s      = mul_finish;
      unit_res_s = mul_out;
    end else begin
      fin_s      = add_finish;
      unit_res_s = add_out;
    end
  end

  assign timer_inc_s = timer_q + TMR_W'(1);

  // Transaction FSM: accept, issue a start pulse, wait for finish or timeout, respond.
  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    a_d          = a_q;
    b_d          = b_q;
    id_d         = id_q;
    last_grant_d = last_grant_q;
    timer_d      = timer_q;
    data_d       = data_q;
    err_d        = err_q;
    rsp_valid_d  = rsp_valid_q;
    add_start_d  = 1'b0;
    mul_start_d  = 1'b0;
    add_sub_d    = add_sub_q;
    case (state_q)
      IDLE: begin
        if (accept_s) begin
          op_d = sel_op_s;
          a_d  = sel_a_s;
          b_d  = sel_b_s;
          id_d = grant_idx_s;
          if (op_is_legal(sel_op_s)) begin
            state_d     = ISSUE;
            add_start_d = (sel_op_s != OP_MUL);
            mul_start_d = (sel_op_s == OP_MUL);
            add_sub_d   = sel_op_s[1];
          end else begin
            // Illegal operator goes straight to an error response.
            state_d     = RESP;
            data_d      = '0;
            err_d       = 1'b1;
            rsp_valid_d = grant_s;
          end
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE: begin
        state_d = WAIT;
        timer_d = '0;
      end
      WAIT: begin
        timer_d = timer_inc_s;
        if (fin_s) begin
          // A finish coinciding with the timeout still counts as success.
          state_d           = RESP;
          data_d            = unit_res_s;
          err_d             = 1'b0;
          rsp_valid_d       = '0;
          rsp_valid_d[id_q] = 1'b1;
        end else if (timer_inc_s == TMR_W'(TIMEOUT_CYCLES - 1)) begin
          state_d           = RESP;
          data_d            = '0;
          err_d             = 1'b1;
          rsp_valid_d       = '0;
          rsp_valid_d[id_q] = 1'b1;
        end else begin
          state_d = WAIT;
        end
      end
      RESP: begin
        if (bus.rsp_ready[id_q]) begin
          state_d      = IDLE;
          rsp_valid_d  = '0;
          last_grant_d = id_q;
        end else begin
          state_d = RESP;
        end
      end
      default: begin
        state_d     = IDLE;
        rsp_valid_d = '0;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (RST) begin
      state_q      <= IDLE;
      op_q         <= 3'b000;
      a_q          <= '0;
      b_q          <= '0;
      id_q         <= '0;
      last_grant_q <= IDX_W'(NUM_REQ - 1);
      timer_q      <= '0;
      data_q       <= '0;
      err_q        <= 1'b0;
      rsp_valid_q  <= '0;
      add_start_q  <= 1'b0;
      mul_start_q  <= 1'b0;
      add_sub_q    <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      a_q          <= a_d;
      b_q          <= b_d;
      id_q         <= id_d;
      last_grant_q <= last_grant_d;
      timer_q      <= timer_d;
      data_q       <= data_d;
      err_q        <= err_d;
      rsp_valid_q  <= rsp_valid_d;
      add_start_q  <= add_start_d;
      mul_start_q  <= mul_start_d;
      add_sub_q    <= add_sub_d;
      busy_q       <= busy_d;
    end
  end

  // Operands come from the latched request and hold until the next accept.
  assign add_in1       = a_q;
  assign add_in2       = b_q;
  assign mul_in1       = a_q;
  assign mul_in2       = b_q;
  assign add_sub       = add_sub_q;
  assign add_start     = add_start_q;
  assign mul_start     = mul_start_q;
  assign busy          = busy_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = data_q;
  assign bus.rsp_error = err_q;

endmodule
